// File: rtl/mips_pkg.sv
// Shared multiplier definitions: FSM state encoding and the iteration count.
// Optional feature macro: MULT_EARLY_TERM_EN.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  localparam int MULT_WIDTH  = 32;
  localparam int MULT_BPC    = 1;
  localparam int MULT_CYCLES = MULT_WIDTH / MULT_BPC;

  function automatic int multCycles(
    input int width,
    input int bpc
  );
    return width / bpc;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One RUN iteration of the shift-add multiplier:
// adds the partial products of the low BITS_PER_CYCLE multiplier bits.
module mult_step
  import mips_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] accNext
);

  always_comb begin
    accNext = acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier[k]) accNext = accNext + (mcand << k);
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative MULT/MULTU sequencer owning HI/LO.
// Define MULT_EARLY_TERM_EN to leave RUN once the multiplier is exhausted.
module mult_seq_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multstartE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiloreadD,
  input  logic             hiweW,
  input  logic             loweW,
  input  logic [WIDTH-1:0] resultW,
  output logic             busy,
  output logic             pve,
  output logic             stallhiloD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW  = 2 * WIDTH;
  localparam int CYC = multCycles(WIDTH, BITS_PER_CYCLE);
  localparam int CW  = $clog2(CYC + 1);

  mult_state_t state, nextState;

  logic [PW-1:0]    acc, mcand, accStep;
  logic [WIDTH-1:0] mplier, mplierNext;
  logic [WIDTH-1:0] aMag, bMag;
  logic [CW-1:0]    cnt;
  logic             neg, start, runLast;

  assign start = multstartE & ((state == IDLE) | (state == DONE));
  assign mplierNext = mplier >> BITS_PER_CYCLE;
  assign aMag = (signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign bMag = (signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;

`ifdef MULT_EARLY_TERM_EN
  assign runLast = (cnt == CW'(1)) | (mplierNext == '0);
`else
  assign runLast = (cnt == CW'(1));
`endif

  mult_step #(
    .WIDTH(WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) uStep (
    .acc(acc),
    .mcand(mcand),
    .mplier(mplier),
    .accNext(accStep)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (multstartE) nextState = RUN;
      RUN:  if (runLast) nextState = FIX;
      FIX:  nextState = DONE;
      DONE: nextState = multstartE ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN) | (state == FIX);
    pve        = (state == DONE);
    // DONE still presents the old HI/LO, so MF reads wait one more cycle
    stallhiloD = hiloreadD & (busy | pve);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, aMag};
      mplier <= bMag;
      cnt    <= CW'(CYC);
      neg    <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
    end else begin
      unique case (state)
        RUN: begin
          acc    <= accStep;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplierNext;
          cnt    <= cnt - CW'(1);
        end
        FIX: if (neg) acc <= -acc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      {hi, lo} <= acc;
    end else begin
      if (hiweW) hi <= resultW;
      if (loweW) lo <= resultW;
    end
  end

endmodule
